// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared Gray/binary pointer helpers for the dual-clock FIFO
package fifo_pkg;

  // Widest pointer the helpers handle; narrower pointers are zero-extended in
  // and truncated out, which is exact for both conversions.
  localparam int PTR_MAXW = 32;

  function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
    logic [PTR_MAXW-1:0] b;
    b[PTR_MAXW-1] = g[PTR_MAXW-1];
    for (int i = PTR_MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// rtl/fifo_out_buf.sv - 2-entry valid/ready output buffer for the FIFO read stream
module fifo_out_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [1:0]    count,
  output logic          valid,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [2];
  logic          head_q, head_d;
  logic [1:0]    count_q, count_d;
  logic          tail;

  // Tail is head plus occupancy; with two entries and a pop in the same cycle
  // the write lands in the slot the pop is vacating.
  always_comb begin
    tail    = head_q ^ count_q[0];
    head_d  = head_q ^ rd_en;
    count_d = count_q + {1'b0, wr_en} - {1'b0, rd_en};
  end

  // Occupancy and head index; cleared asynchronously so the stream drops at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  // Data storage is not reset; contents are only meaningful under count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tail] <= wr_data;
    end
  end

  assign count   = count_q;
  assign valid   = (count_q != 2'd0);
  assign rd_data = mem_q[head_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side pointer/empty control with valid/ready output stream
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATASIZE    = 8,
  parameter int ADDRSIZE    = 4,
  parameter     FALLTHROUGH = "TRUE"
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rclken,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data
);

  localparam int  PW = ADDRSIZE + 1;
  localparam bit  FT = (FALLTHROUGH == "TRUE");

  logic [PW-1:0]       rbin_q, rbin_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [PW-1:0]       rlevel_q, rlevel_d;
  logic                rempty_q, rempty_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          ob_cnt;
  logic [2:0]          ob_fill;
  logic                pop_out;
  logic                rinc;
  logic                buf_wr_en;
  logic [PTR_MAXW-1:0] rgray_w;
  logic [PTR_MAXW-1:0] wbin_w;
  logic                unused_hi;

  // Fetch whenever a buffer slot is (or is about to be) free, counting any
  // word already launched from a registered memory; compute next pointers.
  always_comb begin
    pop_out    = m_valid & m_ready;
    ob_fill    = {1'b0, ob_cnt} + {2'b00, inflight_q};
    rinc       = !rempty_q & ((ob_fill < 3'd2) | pop_out);
    rbin_d     = rbin_q + {{ADDRSIZE{1'b0}}, rinc};
    rgray_w    = bin2gray(PTR_MAXW'(rbin_d));
    rptr_d     = rgray_w[PW-1:0];
    wbin_w     = gray2bin(PTR_MAXW'(rq2_wptr));
    rempty_d   = (rptr_d == rq2_wptr);
    rlevel_d   = wbin_w[PW-1:0] - rbin_d;
    inflight_d = FT ? 1'b0 : rinc;
    buf_wr_en  = FT ? rinc : inflight_q;
  end

  // Pointer, empty, level and in-flight registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      rlevel_q   <= '0;
      rempty_q   <= 1'b1;
      inflight_q <= 1'b0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rlevel_q   <= rlevel_d;
      rempty_q   <= rempty_d;
      inflight_q <= inflight_d;
    end
  end

  fifo_out_buf #(
    .DW (DATASIZE)
  ) u_buf (
    .clk     (rclk),
    .rst_n   (rrst_n),
    .wr_en   (buf_wr_en),
    .wr_data (rdata),
    .rd_en   (pop_out),
    .count   (ob_cnt),
    .valid   (m_valid),
    .rd_data (m_data)
  );

  assign unused_hi = ^{rgray_w[PTR_MAXW-1:PW], wbin_w[PTR_MAXW-1:PW]};

  assign rptr   = rptr_q;
  assign raddr  = rbin_q[ADDRSIZE-1:0];
  assign rclken = rinc;
  assign rempty = rempty_q;
  assign rlevel = rlevel_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench running fall-through and registered instances side by side
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int PW = AW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [PW-1:0] wptr;
  logic [PW-1:0] wbin;
  logic          m_ready;
  logic [DW-1:0] mem [16];

  logic [PW-1:0] rptr_ft, rlevel_ft, rptr_rg, rlevel_rg;
  logic [AW-1:0] raddr_ft, raddr_rg;
  logic          rclken_ft, rempty_ft, m_valid_ft;
  logic          rclken_rg, rempty_rg, m_valid_rg;
  logic [DW-1:0] rdata_ft, m_data_ft, rdata_rg, m_data_rg;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_ft[$];
  logic [DW-1:0] exp_rg[$];
  int pushed = 0;
  int pop_ft = 0;
  int pop_rg = 0;

  fifo_rd_stream #(.DATASIZE(DW), .ADDRSIZE(AW), .FALLTHROUGH("TRUE")) dut_ft (
    .rclk(clk), .rrst_n(rst_n), .rq2_wptr(wptr), .rptr(rptr_ft), .raddr(raddr_ft),
    .rclken(rclken_ft), .rdata(rdata_ft), .rempty(rempty_ft), .rlevel(rlevel_ft),
    .m_valid(m_valid_ft), .m_ready(m_ready), .m_data(m_data_ft));

  fifo_rd_stream #(.DATASIZE(DW), .ADDRSIZE(AW), .FALLTHROUGH("FALSE")) dut_rg (
    .rclk(clk), .rrst_n(rst_n), .rq2_wptr(wptr), .rptr(rptr_rg), .raddr(raddr_rg),
    .rclken(rclken_rg), .rdata(rdata_rg), .rempty(rempty_rg), .rlevel(rlevel_rg),
    .m_valid(m_valid_rg), .m_ready(m_ready), .m_data(m_data_rg));

  // Memory models: combinational read for fall-through, clocked read for registered.
  assign rdata_ft = mem[raddr_ft];
  always @(posedge clk) if (rclken_rg) rdata_rg <= mem[raddr_rg];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] base);
    logic [31:0] g;
    for (int i = 0; i < n; i++) begin
      mem[wbin[AW-1:0]] = base + DW'(i);
      exp_ft.push_back(base + DW'(i));
      exp_rg.push_back(base + DW'(i));
      wbin = wbin + 1'b1;
      pushed++;
    end
    g = bin2gray(32'(wbin));
    wptr = g[PW-1:0];
  endtask

  task automatic do_reset(input bit chk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    wptr = '0;
    wbin = '0;
    m_ready = 1'b0;
    exp_ft.delete();
    exp_rg.delete();
    pushed = 0;
    pop_ft = 0;
    pop_rg = 0;
    #1;
    if (chk) begin
      check("rst_mvalid_ft", m_valid_ft, 0);
      check("rst_mvalid_rg", m_valid_rg, 0);
      check("rst_rempty_ft", rempty_ft, 1);
      check("rst_rempty_rg", rempty_rg, 1);
      check("rst_rptr_ft", rptr_ft, 0);
      check("rst_rptr_rg", rptr_rg, 0);
      check("rst_rlevel_ft", rlevel_ft, 0);
      check("rst_rlevel_rg", rlevel_rg, 0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (exp_ft.size() == 0 && exp_rg.size() == 0) break;
    end
    check({name, "_drain_ft"}, exp_ft.size(), 0);
    check({name, "_drain_rg"}, exp_rg.size(), 0);
  endtask

  // Output monitors: pop expected words, check hold-under-stall and Gray steps.
  logic          stall_ft = 1'b0, stall_rg = 1'b0;
  logic [DW-1:0] pdata_ft, pdata_rg;
  logic [PW-1:0] prptr_ft = '0, prptr_rg = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_ft) begin
        check("hold_valid_ft", m_valid_ft, 1);
        check("hold_data_ft", m_data_ft, pdata_ft);
      end
      if (rptr_ft != prptr_ft) check("gray_step_ft", $countones(rptr_ft ^ prptr_ft), 1);
      if (m_valid_ft && m_ready) begin
        vectors++;
        if (exp_ft.size() == 0) begin
          miscompares++;
          $display("FAIL extra_word_ft: got %0h expected none", m_data_ft);
        end else begin
          vectors--;
          check("data_ft", m_data_ft, exp_ft.pop_front());
        end
        pop_ft++;
      end
      stall_ft = m_valid_ft && !m_ready;
      pdata_ft = m_data_ft;
    end else begin
      stall_ft = 1'b0;
    end
    prptr_ft = rptr_ft;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_rg) begin
        check("hold_valid_rg", m_valid_rg, 1);
        check("hold_data_rg", m_data_rg, pdata_rg);
      end
      if (rptr_rg != prptr_rg) check("gray_step_rg", $countones(rptr_rg ^ prptr_rg), 1);
      if (m_valid_rg && m_ready) begin
        vectors++;
        if (exp_rg.size() == 0) begin
          miscompares++;
          $display("FAIL extra_word_rg: got %0h expected none", m_data_rg);
        end else begin
          vectors--;
          check("data_rg", m_data_rg, exp_rg.pop_front());
        end
        pop_rg++;
      end
      stall_rg = m_valid_rg && !m_ready;
      pdata_rg = m_data_rg;
    end else begin
      stall_rg = 1'b0;
    end
    prptr_rg = rptr_rg;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ft, last_ft, n_ft, first_rg, last_rg, n_rg, pulses_ft, pulses_rg;
    logic saw_msb_ft, saw_msb_rg;
    rst_n = 1'b0;
    wptr = '0;
    wbin = '0;
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("init_rempty_ft", rempty_ft, 1);
    check("init_rempty_rg", rempty_rg, 1);
    check("init_mvalid_ft", m_valid_ft, 0);
    check("init_mvalid_rg", m_valid_rg, 0);
    check("init_rptr_ft", rptr_ft, 0);
    check("init_rlevel_rg", rlevel_rg, 0);
    check("init_rclken_ft", rclken_ft, 0);
    check("init_rclken_rg", rclken_rg, 0);

    // Single word 0xA5
    @(posedge clk); #1;
    m_ready = 1'b1;
    push_words(1, 8'hA5);
    @(negedge clk);
    check("single_c0_rclken_ft", rclken_ft, 0);
    @(negedge clk);
    check("single_c1_rclken_ft", rclken_ft, 1);
    check("single_c1_rclken_rg", rclken_rg, 1);
    check("single_c1_rempty_ft", rempty_ft, 0);
    @(negedge clk);
    check("single_c2_mvalid_ft", m_valid_ft, 1);
    check("single_c2_mvalid_rg", m_valid_rg, 0);
    check("single_c2_rempty_ft", rempty_ft, 1);
    check("single_c2_rempty_rg", rempty_rg, 1);
    check("single_c2_rptr_ft", rptr_ft, 1);
    check("single_c2_rclken_ft", rclken_ft, 0);
    @(negedge clk);
    check("single_c3_mvalid_rg", m_valid_rg, 1);
    check("single_c3_mvalid_ft", m_valid_ft, 0);
    wait_drain("single");

    // Full memory, 16 words streamed with ready high
    do_reset(1'b0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    push_words(16, 8'h00);
    check("full_wptr", wptr, 5'b11000);
    first_ft = -1; last_ft = -1; n_ft = 0;
    first_rg = -1; last_rg = -1; n_rg = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("full_rlevel_ft", rlevel_ft, 16);
        check("full_rlevel_rg", rlevel_rg, 16);
        check("full_rempty_rg", rempty_rg, 0);
      end
      if (m_valid_ft) begin
        if (first_ft < 0) first_ft = c;
        last_ft = c;
        n_ft++;
      end
      if (m_valid_rg) begin
        if (first_rg < 0) first_rg = c;
        last_rg = c;
        n_rg++;
      end
    end
    check("full_first_ft", first_ft, 2);
    check("full_last_ft", last_ft, 17);
    check("full_count_ft", n_ft, 16);
    check("full_first_rg", first_rg, 3);
    check("full_last_rg", last_rg, 18);
    check("full_count_rg", n_rg, 16);
    check("full_end_rempty_rg", rempty_rg, 1);
    check("full_end_rlevel_rg", rlevel_rg, 0);
    check("full_end_rlevel_ft", rlevel_ft, 0);

    // Backpressure: 8 words with ready low
    @(posedge clk); #1;
    m_ready = 1'b0;
    push_words(8, 8'h40);
    pulses_ft = 0; pulses_rg = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rclken_ft) pulses_ft++;
      if (rclken_rg) pulses_rg++;
    end
    check("bp_pulses_ft", pulses_ft, 2);
    check("bp_pulses_rg", pulses_rg, 2);
    check("bp_rlevel_ft", rlevel_ft, 6);
    check("bp_rlevel_rg", rlevel_rg, 6);
    check("bp_obcnt_ft", dut_ft.u_buf.count, 2);

    // Release: pop and fetch in the same cycle with a full buffer
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    check("simul_rclken_ft", rclken_ft, 1);
    check("simul_rclken_rg", rclken_rg, 1);
    @(negedge clk);
    check("simul_obcnt_ft", dut_ft.u_buf.count, 2);
    wait_drain("bp");

    // Reset mid-stream with a full output buffer
    @(posedge clk); #1;
    m_ready = 1'b0;
    push_words(4, 8'h60);
    repeat (6) @(negedge clk);
    check("midrst_obcnt_ft", dut_ft.u_buf.count, 2);
    check("midrst_obcnt_rg", dut_rg.u_buf.count, 2);
    do_reset(1'b1);
    pulses_ft = 0; pulses_rg = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rclken_ft) pulses_ft++;
      if (rclken_rg) pulses_rg++;
    end
    check("postrst_rclken_ft", pulses_ft, 0);
    check("postrst_rclken_rg", pulses_rg, 0);

    // Wrap-around: 40 words with random ready
    saw_msb_ft = 1'b0;
    saw_msb_rg = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int low;
      @(posedge clk); #1;
      if (rptr_ft[PW-1]) saw_msb_ft = 1'b1;
      if (rptr_rg[PW-1]) saw_msb_rg = 1'b1;
      m_ready = 1'($urandom_range(0, 1));
      low = (pop_ft < pop_rg) ? pop_ft : pop_rg;
      if (pushed < 40 && (pushed - low) < 16 && $urandom_range(0, 3) != 0)
        push_words(1, 8'h80 + DW'(pushed));
      if (pushed == 40 && exp_ft.size() == 0 && exp_rg.size() == 0) break;
    end
    m_ready = 1'b1;
    wait_drain("wrap");
    check("wrap_pushed", pushed, 40);
    check("wrap_msb_ft", saw_msb_ft, 1);
    check("wrap_msb_rg", saw_msb_rg, 1);
    check("wrap_rptr_ft", rptr_ft, 5'b01100);
    check("wrap_rptr_rg", rptr_rg, 5'b01100);
    check("wrap_rempty_ft", rempty_ft, 1);
    check("wrap_rlevel_rg", rlevel_rg, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side controller of the dual-clock FIFO: owns the read pointer and empty flag, drives `raddr`/`rclken` into `fifomem`, and presents popped words as a valid/ready stream. Sits entirely in the `rclk` domain; consumes the write pointer already synchronized into that domain and exports its Gray read pointer for synchronization back to the write side. Supports both memory read modes (fall-through and registered) with full throughput.

## Interface
- `DATASIZE`, 8, data word width (must match `fifomem`)
- `ADDRSIZE`, 4, memory address bits; depth = 2^ADDRSIZE
- `FALLTHROUGH`, "TRUE", "TRUE" = `rdata` valid in the cycle `raddr` is driven; otherwise `rdata` is valid one cycle after `rclken`

- `rclk`  in  1  read clock; all state on rising edge
- `rrst_n`  in  1  asynchronous, active-low reset
- `rq2_wptr`  in  ADDRSIZE+1  Gray write pointer, already synchronized to `rclk`
- `rptr`  out  ADDRSIZE+1  registered Gray read pointer, to the write-domain synchronizer
- `raddr`  out  ADDRSIZE  memory read address = `rbin[ADDRSIZE-1:0]`
- `rclken`  out  1  memory read enable; high exactly on cycles that pop a word
- `rdata`  in  DATASIZE  memory read data
- `rempty`  out  1  registered; memory holds no unread words
- `rlevel`  out  ADDRSIZE+1  registered count of words in memory (excludes output buffer)
- `m_valid`  out  1  output word available
- `m_ready`  in  1  downstream accepts
- `m_data`  out  DATASIZE  output word

## Operation
- State: `rbin`/`rptr` (binary/Gray, ADDRSIZE+1 bits), `rempty`, `rlevel`, 2-entry output buffer (`ob_cnt` 0..2, head index), `inflight` (registered mode only).
- `pop_out = m_valid & m_ready`; `m_ready` ignored while `!m_valid`.
- Fetch: `rinc = !rempty & ((ob_cnt + inflight < 2) | pop_out)`; `rclken = rinc`.
- `rbinnext = rbin + rinc` (wraps modulo 2^(ADDRSIZE+1)); `rgraynext = rbinnext ^ (rbinnext >> 1)`.
- `rempty <= (rgraynext == rq2_wptr)`; `rlevel <= gray2bin(rq2_wptr) - rbinnext` (ADDRSIZE+1-bit modulo subtraction).
- Fall-through: on `rinc` edge, `rdata` is written to buffer tail. Registered: `inflight <= rinc`; on the edge after, `rdata` is written to buffer tail.
- `m_valid = ob_cnt != 0`; `m_data` = buffer head; once `m_valid` is high, `m_data` holds until `pop_out`.
- Simultaneous buffer write and `pop_out`: `ob_cnt` unchanged, head advances.
- Full memory (`rlevel == 2^ADDRSIZE`): pointers differ in MSB only; `rempty` stays 0.
- Reset (anytime): `rbin`, `rptr`, `ob_cnt`, head, `inflight`, `rlevel` = 0; `rempty` = 1; `m_valid` = 0; `rclken` = 0; in-flight data discarded. `m_data` and buffer contents not reset.

## Timing
- `rq2_wptr` advance -> `rempty` falls next edge -> `rclken` high that cycle -> `m_valid` next edge (fall-through) or one edge later (registered).
- First word after empty: `m_valid` 2 cycles after `rq2_wptr` change (fall-through), 3 cycles (registered).
- Steady state with `m_ready` held high: one word per cycle in both modes.
- Last word: `rempty` rises on the edge that pops it; no `rclken` while `rempty`.
- `rptr` changes only on `rinc` edges, one Gray bit per change.

## Structure
- Package `fifo_pkg`: `bin2gray`/`gray2bin` functions parameterized by width, shared with write-side pointer logic.
- Sub-module `fifo_out_buf`: 2-entry valid/ready buffer with `wr_en`, `wr_data`, `count` output; controller computes `rinc` from its `count`.

## Test plan
- Reset: `rrst_n`=0 mid-stream with `ob_cnt`=2 -> immediately `m_valid`=0, `rempty`=1, `rptr`=0, `rlevel`=0; after release, no `rclken` until `rq2_wptr` moves.
- Single word, ADDRSIZE=4, fall-through: `rq2_wptr` 0->1, `mem[0]`=0xA5, `m_ready`=1 -> `rclken` at cycle 1, `m_valid`/`m_data`=0xA5 at cycle 2, `rptr`=1, `rempty`=1 after pop.
- Registered mode, 16 words (full, `rq2_wptr`=5'b11000): `rlevel`=16, `rempty`=0; `m_ready`=1 -> 16 consecutive words 0..15 after 3-cycle latency, then `rempty`=1, `rlevel`=0.
- Backpressure: 8 words, `m_ready`=0 -> exactly 2 `rclken` pulses, `rlevel`=6, `m_data` stable; raise `m_ready` -> remaining words in order with no gaps or duplicates.
- Wrap-around: 40 words streamed with random `m_ready` -> `rptr` wraps past 5'b10000 and back to 0, data order preserved, `rptr` single-bit Gray changes.
- Simultaneous: `ob_cnt`=2, `pop_out`=1, `!rempty` -> `rclken`=1 same cycle, `ob_cnt` stays 2 (fall-through).
